data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_wait_counter.sv | 28 ++
 rtl/data_mem_responder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressed data memory responder:
// parameter defaults, word width and the request/response state encoding.
package mem_pkg;

    localparam int DEPTH_DEFAULT       = 32;
    localparam int ADDR_W_DEFAULT      = 5;
    localparam int WAIT_CYCLES_DEFAULT = 2;
    localparam int WORD_W              = 32;
    localparam int CNT_W               = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state down-counter: load arms it with the wait length, done flags the
// last cycle spent waiting so the next edge can move on to the response.
module mem_wait_counter
    import mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= limit;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    // count is 1 during the final wait cycle, so leaving on that edge gives exactly limit cycles
    assign done = (count == CNT_W'(1));

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding word read/write responder over a byte array with
// big-endian lanes, wrap-around addressing and a fixed number of wait states.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEFAULT,
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [WORD_W-1:0] rsp_rdata
);

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              enter_resp;
    logic              wait_done;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [WORD_W-1:0] op_wdata;
    logic [ADDR_W-1:0] lane [4];
    logic [7:0]        mem [DEPTH];

    assign req_ready = (state == IDLE) && rst_n;
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

    mem_wait_counter u_wait_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept && (WAIT_CYCLES > 0)),
        .limit (CNT_W'(WAIT_CYCLES)),
        .done  (wait_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state != RESP) && (state_next == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // With zero wait states RESP is entered on the accept edge itself, before the request registers load
    always_comb begin
        op_we    = (state == IDLE) ? req_we    : we_q;
        op_addr  = (state == IDLE) ? req_addr  : addr_q;
        op_wdata = (state == IDLE) ? req_wdata : wdata_q;
        for (int i = 0; i < 4; i++) begin
            lane[i] = op_addr + ADDR_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
        end else if (enter_resp) begin
            rsp_we <= op_we;
            if (op_we) begin
                mem[lane[0]] <= op_wdata[31:24];
                mem[lane[1]] <= op_wdata[23:16];
                mem[lane[2]] <= op_wdata[15:8];
                mem[lane[3]] <= op_wdata[7:0];
                rsp_rdata    <= '0;
            end else begin
                rsp_rdata <= {mem[lane[0]], mem[lane[1]], mem[lane[2]], mem[lane[3]]};
            end
        end
    end

endmodule
